// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Control/handshake bundle between decoder, fetch sequencer and
//               instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic            halt_req;
  logic            branch_req;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            mem_read;
  logic            mem_write;

  logic [PC_W-1:0] pc;
  logic            commit;
  logic            stall;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [15:0]     instr_retired;
  logic [15:0]     stall_cycles;

  modport master (
    output start, halt_req, branch_req, branch_taken, branch_target,
           mem_read, mem_write,
    input  pc, commit, stall, busy, done, overflow, instr_retired, stall_cycles
  );

  modport slave (
    input  start, halt_req, branch_req, branch_taken, branch_target,
           mem_read, mem_write,
    output pc, commit, stall, busy, done, overflow, instr_retired, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : PC owner and run/halt sequencer for the 9-bit core; issues the
//               commit strobe and stalls for multi-cycle data-memory accesses.
//               Optional macro PERF_CNT_EN builds the retire/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int MEM_LAT    = 2,
  parameter int START_ADDR = 0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fetch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] c_start  = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] c_pc_max = '1;
  localparam logic [2:0]      c_lat_m1 = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_cnt;
  logic            r_overflow;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [2:0]      w_cnt_nxt;
  logic            w_overflow_nxt;
  logic            w_commit_raw;
  logic            w_stall_raw;
  logic            w_advance;
  logic            w_commit;
  logic            w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= c_start;
      r_cnt      <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_cnt_nxt      = r_cnt;
    w_overflow_nxt = r_overflow;
    w_commit_raw   = 1'b0;
    w_stall_raw    = 1'b0;
    w_advance      = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt    = S_RUN;
          w_pc_nxt       = c_start;
          w_overflow_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.halt_req) begin
          w_commit_raw = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (bus.branch_req) begin
          w_commit_raw = 1'b1;
          if (bus.branch_taken) begin
            w_pc_nxt = bus.branch_target;
          end else begin
            w_advance = 1'b1;
          end
        end else if ((bus.mem_read || bus.mem_write) && (MEM_LAT > 0)) begin
          w_stall_raw = 1'b1;
          w_cnt_nxt   = c_lat_m1;
          w_state_nxt = S_MEMWAIT;
        end else begin
          w_commit_raw = 1'b1;
          w_advance    = 1'b1;
        end
      end
      S_MEMWAIT: begin
        if (r_cnt != 3'd0) begin
          w_stall_raw = 1'b1;
          w_cnt_nxt   = r_cnt - 3'd1;
        end else begin
          w_commit_raw = 1'b1;
          w_advance    = 1'b1;
          w_state_nxt  = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Sequential advance past the last address finishes instead of wrapping.
    if (w_advance) begin
      if (r_pc == c_pc_max) begin
        w_state_nxt    = S_DONE;
        w_overflow_nxt = 1'b1;
      end else begin
        w_pc_nxt = r_pc + 1'b1;
      end
    end
  end

  assign w_commit = w_commit_raw & ~reset;
  assign w_stall  = w_stall_raw & ~reset;

  assign bus.pc       = r_pc;
  assign bus.commit   = w_commit;
  assign bus.stall    = w_stall;
  assign bus.busy     = (r_state == S_RUN) || (r_state == S_MEMWAIT);
  assign bus.done     = (r_state == S_DONE);
  assign bus.overflow = r_overflow;

`ifdef PERF_CNT_EN
  logic        w_start_acc;
  logic [15:0] r_instr_retired;
  logic [15:0] r_stall_cycles;

  assign w_start_acc = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_instr_retired <= 16'd0;
      r_stall_cycles  <= 16'd0;
    end else begin
      if (w_commit && (r_instr_retired != 16'hFFFF)) begin
        r_instr_retired <= r_instr_retired + 16'd1;
      end
      if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign bus.instr_retired = r_instr_retired;
  assign bus.stall_cycles  = r_stall_cycles;
`else
  assign bus.instr_retired = 16'd0;
  assign bus.stall_cycles  = 16'd0;
`endif

endmodule

`default_nettype wire
